// File: rtl/acc_datapath_pkg.sv
// Shared codes for the accumulator datapath: ALU ops, write/operand selects,
// flag bit positions and the FSM state encoding.
package acc_datapath_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_SRA = 3'd7
    } op_t;

    localparam logic [1:0] SELA_MEM  = 2'd0;
    localparam logic [1:0] SELA_IMM  = 2'd1;
    localparam logic [1:0] SELA_ALU  = 2'd2;
    localparam logic [1:0] SELA_HOLD = 2'd3;

    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU: ADD/SUB/logic plus a single-bit shift step and flag word.
// ACC_SAT_EN: when defined, ADD/SUB clamp to the signed range on overflow.
module acc_alu
    import acc_datapath_pkg::*;
#(
    parameter int NBITS_D = 16
) (
    input  op_t                op,
    input  logic [NBITS_D-1:0] a,
    input  logic [NBITS_D-1:0] b,
    input  logic               step,
    output logic [NBITS_D-1:0] result,
    output logic [3:0]         flags
);

    localparam int MSB = NBITS_D - 1;

    logic [NBITS_D-1:0] b_eff;
    logic [NBITS_D:0]   sum;
    logic               cin;
    logic               ovf;
    logic               c;
    logic               v;

    always_comb begin
        b_eff  = b;
        cin    = 1'b0;
        if (op == OP_SUB) begin
            b_eff = ~b;
            cin   = 1'b1;
        end
        sum    = {1'b0, a} + {1'b0, b_eff} + {{NBITS_D{1'b0}}, cin};
        ovf    = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
        result = a;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result = sum[NBITS_D-1:0];
                c      = sum[NBITS_D];
                v      = ovf;
`ifdef ACC_SAT_EN
                // On overflow the true result has the sign of A.
                if (ovf) begin
                    result = a[MSB] ? {1'b1, {(NBITS_D-1){1'b0}}}
                                    : {1'b0, {(NBITS_D-1){1'b1}}};
                end
`endif
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = step ? {a[MSB-1:0], 1'b0} : a;
                c      = step & a[MSB];
            end
            OP_SHR: begin
                result = step ? {1'b0, a[MSB:1]} : a;
                c      = step & a[0];
            end
            OP_SRA: begin
                result = step ? {a[MSB], a[MSB:1]} : a;
                c      = step & a[0];
            end
            default: result = a;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[MSB];
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/acc_datapath_mc.sv
// Accumulator bank with ALU, registered flags and iterative multi-cycle shifts.
// ACC_SAT_EN selects saturating ADD/SUB inside acc_alu.
module acc_datapath_mc
    import acc_datapath_pkg::*;
#(
    parameter  int NBITS_O = 11,
    parameter  int NBITS_D = 16,
    parameter  int NACC    = 4,
    localparam int ACCW    = $clog2(NACC),
    localparam int SHW     = $clog2(NBITS_D)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_SelA,
    input  logic               i_SelB,
    input  logic               i_WrAcc,
    input  logic [2:0]         i_Op,
    input  logic [ACCW-1:0]    i_AccSel,
    input  logic [NBITS_O-1:0] i_Operand,
    input  logic [NBITS_D-1:0] i_OutData,
    output logic [NBITS_D-1:0] o_InData,
    output logic [3:0]         o_flags,
    output logic               o_done,
    output state_t             o_state
);

    // Handshake: a command is taken on a rising edge with i_valid && o_ready;
    // o_ready is high only in IDLE and i_valid is ignored otherwise.

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [NBITS_D-1:0]  acc [NACC];
    logic [SHW-1:0]      cnt;
    logic [ACCW-1:0]     idx_q;
    op_t                 op_q;
    logic [3:0]          flags;
    logic                done;

    logic [NBITS_D-1:0]  ext_imm;
    logic [NBITS_D-1:0]  opb;
    logic [SHW-1:0]      count_in;
    logic                is_shift;
    logic                accept;
    logic                go_shift;
    logic                in_shift;
    op_t                 alu_op;
    logic [NBITS_D-1:0]  alu_a;
    logic [NBITS_D-1:0]  alu_res;
    logic [3:0]          alu_flags;

    assign ext_imm  = {{(NBITS_D-NBITS_O){i_Operand[NBITS_O-1]}}, i_Operand};
    assign opb      = (i_SelB == SELB_IMM) ? ext_imm : i_OutData;
    assign count_in = opb[SHW-1:0];
    assign is_shift = (i_Op == OP_SHL) || (i_Op == OP_SHR) || (i_Op == OP_SRA);
    assign o_ready  = (state == ST_IDLE);
    assign accept   = i_valid && o_ready;
    assign go_shift = accept && is_shift && (count_in != '0) && i_WrAcc && (i_SelA == SELA_ALU);
    assign in_shift = (state == ST_SHIFT);

    // During SHIFT the latched index and op drive the ALU and the read port.
    assign alu_op   = in_shift ? op_q : op_t'(i_Op);
    assign alu_a    = in_shift ? acc[idx_q] : acc[i_AccSel];
    assign o_InData = alu_a;
    assign o_flags  = flags;
    assign o_done   = done;
    assign o_state  = state;

    acc_alu #(.NBITS_D(NBITS_D)) u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (opb),
        .step   (in_shift),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (go_shift) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_ONE) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt   <= '0;
            idx_q <= '0;
            op_q  <= OP_ADD;
            flags <= '0;
            done  <= 1'b0;
            for (int i = 0; i < NACC; i++) acc[i] <= '0;
        end else begin
            done <= 1'b0;
            if (in_shift) begin
                acc[idx_q] <= alu_res;
                cnt        <= cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    flags <= alu_flags;
                    done  <= 1'b1;
                end
            end else if (go_shift) begin
                cnt   <= count_in;
                idx_q <= i_AccSel;
                op_q  <= op_t'(i_Op);
            end else if (accept) begin
                done <= 1'b1;
                if (i_WrAcc) begin
                    case (i_SelA)
                        SELA_MEM: acc[i_AccSel] <= i_OutData;
                        SELA_IMM: acc[i_AccSel] <= ext_imm;
                        SELA_ALU: begin
                            acc[i_AccSel] <= alu_res;
                            flags         <= alu_flags;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_datapath_mc.sv
// Bench for acc_datapath_mc: directed vector table, random commands against a
// behavioural model, and a reset-during-shift sequence. Honours ACC_SAT_EN.
module tb_acc_datapath_mc;
    import acc_datapath_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_SelA = 2'd3;
    logic        i_SelB = 1'b0;
    logic        i_WrAcc = 1'b0;
    logic [2:0]  i_Op = 3'd0;
    logic [1:0]  i_AccSel = 2'd0;
    logic [10:0] i_Operand = '0;
    logic [15:0] i_OutData = '0;
    logic [15:0] o_InData;
    logic [3:0]  o_flags;
    logic        o_done;
    state_t      o_state;

    acc_datapath_mc #(.NBITS_O(11), .NBITS_D(16), .NACC(4)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_SelA(i_SelA), .i_SelB(i_SelB), .i_WrAcc(i_WrAcc), .i_Op(i_Op),
        .i_AccSel(i_AccSel), .i_Operand(i_Operand), .i_OutData(i_OutData),
        .o_InData(o_InData), .o_flags(o_flags), .o_done(o_done), .o_state(o_state)
    );

    always #5 i_clock = ~i_clock;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_acc [4];
    logic [3:0]  m_flags;
    logic [15:0] mid_val;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  flags;
    } res_t;

    typedef struct {
        logic [1:0]  sela;
        logic        selb;
        logic        wr;
        logic [2:0]  op;
        logic [1:0]  idx;
        logic [10:0] imm;
        logic [15:0] mem;
        logic [15:0] exp_val;
        logic [3:0]  exp_flags;
        int          exp_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU over the whole count at once, from signed/unsigned arithmetic.
    function automatic res_t model_alu(input logic [2:0] op, input logic [15:0] a,
                                       input logic [15:0] b);
        res_t r;
        int n, st;
        logic [16:0] u;
        logic c, v;
        n = int'(b[3:0]);
        c = 1'b0;
        v = 1'b0;
        st = 0;
        r.val = a;
        case (op)
            3'd0, 3'd1: begin
                if (op == 3'd0) begin
                    u  = {1'b0, a} + {1'b0, b};
                    st = int'($signed(a)) + int'($signed(b));
                end else begin
                    u  = {1'b0, a} + {1'b0, ~b} + 17'd1;
                    st = int'($signed(a)) - int'($signed(b));
                end
                r.val = u[15:0];
                c = u[16];
                v = (st > 32767) || (st < -32768);
`ifdef ACC_SAT_EN
                if (st > 32767)  r.val = 16'h7FFF;
                if (st < -32768) r.val = 16'h8000;
`endif
            end
            3'd2: r.val = a & b;
            3'd3: r.val = a | b;
            3'd4: r.val = a ^ b;
            3'd5: begin
                r.val = a << n;
                if (n > 0) c = a[16-n];
            end
            3'd6: begin
                r.val = a >> n;
                if (n > 0) c = a[n-1];
            end
            default: begin
                r.val = 16'($signed(a) >>> n);
                if (n > 0) c = a[n-1];
            end
        endcase
        r.flags = {v, c, r.val[15], (r.val == 16'h0)};
        return r;
    endfunction

    task automatic check_accs(input string name);
        for (int k = 0; k < 4; k++) begin
            i_AccSel = 2'(k);
            #1;
            check(name, {16'h0, o_InData}, {16'h0, m_acc[k]});
        end
    endtask

    task automatic run_cmd(input logic [1:0] sela, input logic selb, input logic wr,
                           input logic [2:0] op, input logic [1:0] idx,
                           input logic [10:0] imm, input logic [15:0] mem,
                           output int busy);
        logic [15:0] ext, b;
        res_t r;
        int n, exp_busy;
        ext = {{5{imm[10]}}, imm};
        b = selb ? ext : mem;
        n = int'(b[3:0]);
        exp_busy = ((op >= 3'd5) && wr && (sela == 2'd2) && (n > 0)) ? n : 0;
        if (wr) begin
            case (sela)
                2'd0: m_acc[idx] = mem;
                2'd1: m_acc[idx] = ext;
                2'd2: begin
                    r = model_alu(op, m_acc[idx], b);
                    m_acc[idx] = r.val;
                    m_flags = r.flags;
                end
                default: ;
            endcase
        end
        i_SelA = sela; i_SelB = selb; i_WrAcc = wr; i_Op = op;
        i_AccSel = idx; i_Operand = imm; i_OutData = mem; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        busy = 0;
        while (!o_ready && busy < 40) begin
            if (busy == 1) mid_val = o_InData;
            // Garbage commands while busy must be ignored.
            i_valid = 1'b1; i_SelA = 2'($urandom); i_SelB = 1'($urandom);
            i_WrAcc = 1'b1; i_Op = 3'($urandom); i_AccSel = 2'($urandom);
            i_Operand = 11'($urandom); i_OutData = 16'($urandom);
            @(posedge i_clock); #1;
            i_valid = 1'b0;
            busy++;
        end
        check("busy_cycles", 32'(busy), 32'(exp_busy));
        check("done_pulse", {31'h0, o_done}, 32'h1);
        check("flags", {28'h0, o_flags}, {28'h0, m_flags});
        check_accs("acc_value");
        @(posedge i_clock); #1;
        check("done_drop", {31'h0, o_done}, 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        logic seen_done;
        //         sela  selb  wr    op    idx   imm       mem        exp_val   flags busy
        vecs[0]  = '{2'd1, 1'b0, 1'b1, 3'd0, 2'd0, 11'h7FF, 16'h0000, 16'hFFFF, 4'h0, 0};
        vecs[1]  = '{2'd0, 1'b0, 1'b1, 3'd0, 2'd0, 11'h000, 16'h7FFF, 16'h7FFF, 4'h0, 0};
`ifdef ACC_SAT_EN
        vecs[2]  = '{2'd2, 1'b0, 1'b1, 3'd0, 2'd0, 11'h000, 16'h0001, 16'h7FFF, 4'h8, 0};
        vecs[3]  = '{2'd1, 1'b0, 1'b1, 3'd0, 2'd2, 11'h005, 16'h0000, 16'h0005, 4'h8, 0};
`else
        vecs[2]  = '{2'd2, 1'b0, 1'b1, 3'd0, 2'd0, 11'h000, 16'h0001, 16'h8000, 4'hA, 0};
        vecs[3]  = '{2'd1, 1'b0, 1'b1, 3'd0, 2'd2, 11'h005, 16'h0000, 16'h0005, 4'hA, 0};
`endif
        vecs[4]  = '{2'd2, 1'b1, 1'b1, 3'd1, 2'd2, 11'h005, 16'h0000, 16'h0000, 4'h5, 0};
        vecs[5]  = '{2'd0, 1'b0, 1'b1, 3'd0, 2'd1, 11'h000, 16'h8001, 16'h8001, 4'h5, 0};
        vecs[6]  = '{2'd2, 1'b1, 1'b1, 3'd5, 2'd1, 11'h004, 16'h0000, 16'h0010, 4'h0, 4};
        vecs[7]  = '{2'd0, 1'b0, 1'b1, 3'd0, 2'd3, 11'h000, 16'h8000, 16'h8000, 4'h0, 0};
        vecs[8]  = '{2'd2, 1'b1, 1'b1, 3'd7, 2'd3, 11'h00F, 16'h0000, 16'hFFFF, 4'h2, 15};
        vecs[9]  = '{2'd2, 1'b1, 1'b1, 3'd7, 2'd3, 11'h000, 16'h0000, 16'hFFFF, 4'h2, 0};
        vecs[10] = '{2'd1, 1'b1, 1'b1, 3'd6, 2'd0, 11'h003, 16'h0000, 16'h0003, 4'h2, 0};
        vecs[11] = '{2'd3, 1'b0, 1'b1, 3'd0, 2'd0, 11'h000, 16'h1234, 16'h0003, 4'h2, 0};
        vecs[12] = '{2'd2, 1'b0, 1'b0, 3'd0, 2'd0, 11'h000, 16'h0005, 16'h0003, 4'h2, 0};
        vecs[13] = '{2'd2, 1'b0, 1'b1, 3'd0, 2'd0, 11'h000, 16'h0003, 16'h0006, 4'h0, 0};

        for (int k = 0; k < 4; k++) m_acc[k] = '0;
        m_flags = '0;
        mid_val = '0;

        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        check("reset_ready", {31'h0, o_ready}, 32'h1);
        check("reset_flags", {28'h0, o_flags}, 32'h0);
        check("reset_done", {31'h0, o_done}, 32'h0);
        check("reset_state", {31'h0, o_state}, {31'h0, ST_IDLE});
        check_accs("reset_acc");

        for (int i = 0; i < 14; i++) begin
            run_cmd(vecs[i].sela, vecs[i].selb, vecs[i].wr, vecs[i].op, vecs[i].idx,
                    vecs[i].imm, vecs[i].mem, busy);
            check("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
            check("vec_flags", {28'h0, o_flags}, {28'h0, vecs[i].exp_flags});
            i_AccSel = vecs[i].idx;
            #1;
            check("vec_value", {16'h0, o_InData}, {16'h0, vecs[i].exp_val});
            if (i == 6) check("shift_midvalue", {16'h0, mid_val}, 32'h0002);
        end

        for (int i = 0; i < 150; i++) begin
            run_cmd(2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                    3'($urandom), 2'($urandom), 11'($urandom), 16'($urandom), busy);
        end

        // Reset in the second SHIFT cycle of a 5-step shift.
        run_cmd(2'd0, 1'b0, 1'b1, 3'd0, 2'd1, 11'h000, 16'h8001, busy);
        run_cmd(2'd2, 1'b0, 1'b1, 3'd0, 2'd1, 11'h000, 16'h8000, busy);
        i_SelA = 2'd2; i_SelB = 1'b1; i_WrAcc = 1'b1; i_Op = 3'd5;
        i_AccSel = 2'd1; i_Operand = 11'd5; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        check("abort_busy", {31'h0, o_ready}, 32'h0);
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) m_acc[k] = '0;
        m_flags = '0;
        check("abort_ready", {31'h0, o_ready}, 32'h1);
        check("abort_flags", {28'h0, o_flags}, 32'h0);
        check("abort_done", {31'h0, o_done}, 32'h0);
        check_accs("abort_acc");
        @(negedge i_clock);
        i_reset = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clock); #1;
            if (o_done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'h0, seen_done}, 32'h0);
        check("abort_ready_after", {31'h0, o_ready}, 32'h1);
        check_accs("abort_acc_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
